// File: rtl/top_system.sv
// Minimal 6502-compatible microcomputer: reduced-opcode CPU plus 4 KB ROM / 4 KB RAM.
// Architectural state advances on rising ph2; ph1 only carries the other clock phase.

// Memory block: RAM at 0x0000-0x0FFF, ROM at 0xF000-0xFFFF, everything else reads 0.
module top_system_mem (
    input  logic        clk,
    input  logic [15:0] i_addr,
    input  logic        i_we,
    input  logic        i_rom_we,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata
);
    logic [7:0] RAM [0:4095];
    logic [7:0] ROM [0:4095];
    logic       w_sel_ram;
    logic       w_sel_rom;

    assign w_sel_ram = (i_addr[15:12] == 4'h0);
    assign w_sel_rom = (i_addr[15:12] == 4'hF);

    // Combinational read through the address map
    always_comb begin
        o_rdata = 8'h00;
        if (w_sel_ram) begin
            o_rdata = RAM[i_addr[11:0]];
        end else if (w_sel_rom) begin
            o_rdata = ROM[i_addr[11:0]];
        end
    end

    // RAM write port; writes outside the RAM window are dropped
    always_ff @(posedge clk) begin
        if (i_we && w_sel_ram) begin
            RAM[i_addr[11:0]] <= i_wdata;
        end
    end

    // ROM image load port; the CPU never enables it, contents come from preload
    always_ff @(posedge clk) begin
        if (i_rom_we && w_sel_rom) begin
            ROM[i_addr[11:0]] <= i_wdata;
        end
    end
endmodule

module top_system (
    input  logic ph1,
    input  logic ph2,
    input  logic reset
);
    typedef enum logic [3:0] {
        S_RESET, S_VECLO, S_VECHI, S_FETCH, S_OPLO,
        S_OPHI, S_READ, S_MODIFY, S_WRITE, S_BRANCH
    } state_t;
    typedef enum logic [2:0] {M_IMPL, M_IMM, M_ZP, M_ABS, M_REL, M_JMP} mode_t;
    typedef enum logic [4:0] {
        K_NOP, K_LD, K_ST, K_INC, K_DEC, K_CMP, K_INX, K_INY, K_DEX, K_DEY,
        K_TAX, K_TXA, K_TAY, K_TYA, K_CLC, K_SEC, K_BEQ, K_BNE
    } kind_t;
    localparam logic [1:0] R_A = 2'd0, R_X = 2'd1, R_Y = 2'd2;

    state_t      r_state;
    logic [7:0]  r_a, r_x, r_y, r_ir, r_dl;
    logic        r_n, r_z, r_c;
    logic [15:0] r_pc, r_addr;

    mode_t       w_mode;
    kind_t       w_kind;
    logic [1:0]  w_reg;
    logic [7:0]  w_src, w_rdata, w_wdata, w_rmw_val, w_cmp_diff, w_wb_val;
    logic [15:0] w_addr;
    logic        w_we, w_sync, w_take, w_wb_en, w_is_rmw;
    logic [1:0]  w_wb_sel;
    logic        w_unused_ph1;

    assign w_unused_ph1 = ph1;

    top_system_mem mem (
        .clk      (ph2),
        .i_addr   (w_addr),
        .i_we     (w_we),
        .i_rom_we (1'b0),
        .i_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    assign w_sync     = (r_state == S_FETCH);
    assign w_is_rmw   = (w_kind == K_INC) || (w_kind == K_DEC);
    assign w_rmw_val  = (w_kind == K_INC) ? r_dl + 8'd1 : r_dl - 8'd1;
    assign w_cmp_diff = r_a - w_rdata;
    assign w_take     = (w_kind == K_BEQ) ? r_z : !r_z;
    // Reset wins over a write landing on the same edge, so an aborted instruction stores nothing
    assign w_we       = (r_state == S_WRITE) && !reset;
    assign w_wdata    = w_is_rmw ? r_dl : w_src;

    // Opcode decode from the latched instruction register
    always_comb begin
        w_mode = M_IMPL;
        w_kind = K_NOP;
        w_reg  = R_A;
        case (r_ir)
            8'hA9: begin w_mode = M_IMM; w_kind = K_LD; end
            8'hA5: begin w_mode = M_ZP;  w_kind = K_LD; end
            8'hAD: begin w_mode = M_ABS; w_kind = K_LD; end
            8'hA2: begin w_mode = M_IMM; w_kind = K_LD; w_reg = R_X; end
            8'hA6: begin w_mode = M_ZP;  w_kind = K_LD; w_reg = R_X; end
            8'hAE: begin w_mode = M_ABS; w_kind = K_LD; w_reg = R_X; end
            8'hA0: begin w_mode = M_IMM; w_kind = K_LD; w_reg = R_Y; end
            8'hA4: begin w_mode = M_ZP;  w_kind = K_LD; w_reg = R_Y; end
            8'hAC: begin w_mode = M_ABS; w_kind = K_LD; w_reg = R_Y; end
            8'h85: begin w_mode = M_ZP;  w_kind = K_ST; end
            8'h8D: begin w_mode = M_ABS; w_kind = K_ST; end
            8'h86: begin w_mode = M_ZP;  w_kind = K_ST; w_reg = R_X; end
            8'h8E: begin w_mode = M_ABS; w_kind = K_ST; w_reg = R_X; end
            8'h84: begin w_mode = M_ZP;  w_kind = K_ST; w_reg = R_Y; end
            8'h8C: begin w_mode = M_ABS; w_kind = K_ST; w_reg = R_Y; end
            8'hE6: begin w_mode = M_ZP;  w_kind = K_INC; end
            8'hEE: begin w_mode = M_ABS; w_kind = K_INC; end
            8'hC6: begin w_mode = M_ZP;  w_kind = K_DEC; end
            8'hCE: begin w_mode = M_ABS; w_kind = K_DEC; end
            8'hE8: w_kind = K_INX;
            8'hC8: w_kind = K_INY;
            8'hCA: w_kind = K_DEX;
            8'h88: w_kind = K_DEY;
            8'hAA: w_kind = K_TAX;
            8'h8A: w_kind = K_TXA;
            8'hA8: w_kind = K_TAY;
            8'h98: w_kind = K_TYA;
            8'h18: w_kind = K_CLC;
            8'h38: w_kind = K_SEC;
            8'hC9: begin w_mode = M_IMM; w_kind = K_CMP; end
            8'hF0: begin w_mode = M_REL; w_kind = K_BEQ; end
            8'hD0: begin w_mode = M_REL; w_kind = K_BNE; end
            8'h4C: w_mode = M_JMP;
            default: ;
        endcase
    end

    // Store source register selection
    always_comb begin
        case (w_reg)
            R_X:     w_src = r_x;
            R_Y:     w_src = r_y;
            default: w_src = r_a;
        endcase
    end

    // Bus address: vector bytes, PC for opcode/operands, address latch for data
    always_comb begin
        w_addr = r_pc;
        if (w_sync) begin
            w_addr = r_pc;
        end else if (r_state == S_VECLO) begin
            w_addr = 16'hFFFC;
        end else if (r_state == S_VECHI) begin
            w_addr = 16'hFFFD;
        end else if (r_state == S_READ || r_state == S_MODIFY || r_state == S_WRITE) begin
            w_addr = r_addr;
        end
    end

    // Register write-back with N/Z update for loads, transfers and index inc/dec
    always_comb begin
        w_wb_en  = 1'b0;
        w_wb_sel = w_reg;
        w_wb_val = w_rdata;
        if (r_state == S_OPLO && w_mode == M_IMPL) begin
            case (w_kind)
                K_INX: begin w_wb_en = 1'b1; w_wb_sel = R_X; w_wb_val = r_x + 8'd1; end
                K_INY: begin w_wb_en = 1'b1; w_wb_sel = R_Y; w_wb_val = r_y + 8'd1; end
                K_DEX: begin w_wb_en = 1'b1; w_wb_sel = R_X; w_wb_val = r_x - 8'd1; end
                K_DEY: begin w_wb_en = 1'b1; w_wb_sel = R_Y; w_wb_val = r_y - 8'd1; end
                K_TAX: begin w_wb_en = 1'b1; w_wb_sel = R_X; w_wb_val = r_a; end
                K_TXA: begin w_wb_en = 1'b1; w_wb_sel = R_A; w_wb_val = r_x; end
                K_TAY: begin w_wb_en = 1'b1; w_wb_sel = R_Y; w_wb_val = r_a; end
                K_TYA: begin w_wb_en = 1'b1; w_wb_sel = R_A; w_wb_val = r_y; end
                default: ;
            endcase
        end else if ((r_state == S_OPLO && w_mode == M_IMM) || r_state == S_READ) begin
            w_wb_en = (w_kind == K_LD);
        end
    end

    // CPU state machine: one state per bus cycle
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state <= S_RESET;
            r_a     <= 8'h00;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_pc    <= 16'h0000;
            r_ir    <= 8'hEA;
            r_addr  <= 16'h0000;
            r_dl    <= 8'h00;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_VECLO;
                S_VECLO: begin
                    r_addr[7:0] <= w_rdata;
                    r_state     <= S_VECHI;
                end
                S_VECHI: begin
                    r_pc    <= {w_rdata, r_addr[7:0]};
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_ir    <= w_rdata;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= S_OPLO;
                end
                S_OPLO: begin
                    case (w_mode)
                        M_IMPL: begin
                            // Implied ops peek at the next byte but do not consume it
                            if (w_kind == K_CLC) r_c <= 1'b0;
                            if (w_kind == K_SEC) r_c <= 1'b1;
                            r_state <= S_FETCH;
                        end
                        M_IMM: begin
                            r_pc <= r_pc + 16'd1;
                            if (w_kind == K_CMP) begin
                                r_c <= (r_a >= w_rdata);
                                r_z <= (r_a == w_rdata);
                                r_n <= w_cmp_diff[7];
                            end
                            r_state <= S_FETCH;
                        end
                        M_REL: begin
                            r_pc    <= r_pc + 16'd1;
                            r_dl    <= w_rdata;
                            r_state <= w_take ? S_BRANCH : S_FETCH;
                        end
                        M_ZP: begin
                            r_pc    <= r_pc + 16'd1;
                            r_addr  <= {8'h00, w_rdata};
                            r_state <= (w_kind == K_ST) ? S_WRITE : S_READ;
                        end
                        default: begin
                            r_pc        <= r_pc + 16'd1;
                            r_addr[7:0] <= w_rdata;
                            r_state     <= S_OPHI;
                        end
                    endcase
                end
                S_OPHI: begin
                    if (w_mode == M_JMP) begin
                        r_pc    <= {w_rdata, r_addr[7:0]};
                        r_state <= S_FETCH;
                    end else begin
                        r_pc         <= r_pc + 16'd1;
                        r_addr[15:8] <= w_rdata;
                        r_state      <= (w_kind == K_ST) ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    r_dl    <= w_rdata;
                    r_state <= w_is_rmw ? S_MODIFY : S_FETCH;
                end
                S_MODIFY: begin
                    r_dl    <= w_rmw_val;
                    r_n     <= w_rmw_val[7];
                    r_z     <= (w_rmw_val == 8'h00);
                    r_state <= S_WRITE;
                end
                S_WRITE: r_state <= S_FETCH;
                S_BRANCH: begin
                    r_pc    <= r_pc + {{8{r_dl[7]}}, r_dl};
                    r_state <= S_FETCH;
                end
                default: r_state <= S_RESET;
            endcase
            if (w_wb_en) begin
                case (w_wb_sel)
                    R_X:     r_x <= w_wb_val;
                    R_Y:     r_y <= w_wb_val;
                    default: r_a <= w_wb_val;
                endcase
                r_n <= w_wb_val[7];
                r_z <= (w_wb_val == 8'h00);
            end
        end
    end
endmodule

// File: tb/tb_top_system.sv
// Bench for top_system: directed programs from the test plan plus random programs,
// each compared against an instruction-level model of the CPU and memory map.
module tb_top_system;
    logic ph1, ph2, reset;

    top_system dut (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]  m_rom [0:4095];
    logic [7:0]  m_ram [0:4095];
    logic [7:0]  m_a, m_x, m_y;
    logic        m_n, m_z, m_c;
    logic [15:0] m_pc;
    logic [15:0] halt_pc;
    logic [7:0]  prog [$];
    logic [7:0]  impl_ops [0:11];

    // Two non-overlapping phases, 20 ns period
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #8 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #8 ph2 = 1'b0;
            #2;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ph2);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] mrd(input logic [15:0] a);
        if (a[15:12] == 4'h0) return m_ram[a[11:0]];
        if (a[15:12] == 4'hF) return m_rom[a[11:0]];
        return 8'h00;
    endfunction

    task automatic mwr(input logic [15:0] a, input logic [7:0] v);
        if (a[15:12] == 4'h0) m_ram[a[11:0]] = v;
    endtask

    task automatic setnz(input logic [7:0] v);
        m_n = v[7];
        m_z = (v == 8'h00);
    endtask

    function automatic logic [7:0] p_of(input logic n, input logic z, input logic c);
        return {n, 1'b0, 1'b1, 3'b000, z, c};
    endfunction

    task automatic model_reset();
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00;
        m_n = 1'b0;  m_z = 1'b0;  m_c = 1'b0;
        m_pc = {m_rom[4093], m_rom[4092]};
    endtask

    // Execute one whole instruction; returns its cycle count
    task automatic model_step(output int cyc);
        logic [7:0]  op, b1, b2, v;
        logic [15:0] zp, ab, nxt;
        op  = mrd(m_pc);
        b1  = mrd(m_pc + 16'd1);
        b2  = mrd(m_pc + 16'd2);
        zp  = {8'h00, b1};
        ab  = {b2, b1};
        nxt = m_pc + 16'd1;
        cyc = 2;
        case (op)
            8'hA9: begin m_a = b1; setnz(m_a); nxt = m_pc + 16'd2; end
            8'hA2: begin m_x = b1; setnz(m_x); nxt = m_pc + 16'd2; end
            8'hA0: begin m_y = b1; setnz(m_y); nxt = m_pc + 16'd2; end
            8'hA5: begin m_a = mrd(zp); setnz(m_a); nxt = m_pc + 16'd2; cyc = 3; end
            8'hA6: begin m_x = mrd(zp); setnz(m_x); nxt = m_pc + 16'd2; cyc = 3; end
            8'hA4: begin m_y = mrd(zp); setnz(m_y); nxt = m_pc + 16'd2; cyc = 3; end
            8'hAD: begin m_a = mrd(ab); setnz(m_a); nxt = m_pc + 16'd3; cyc = 4; end
            8'hAE: begin m_x = mrd(ab); setnz(m_x); nxt = m_pc + 16'd3; cyc = 4; end
            8'hAC: begin m_y = mrd(ab); setnz(m_y); nxt = m_pc + 16'd3; cyc = 4; end
            8'h85: begin mwr(zp, m_a); nxt = m_pc + 16'd2; cyc = 3; end
            8'h86: begin mwr(zp, m_x); nxt = m_pc + 16'd2; cyc = 3; end
            8'h84: begin mwr(zp, m_y); nxt = m_pc + 16'd2; cyc = 3; end
            8'h8D: begin mwr(ab, m_a); nxt = m_pc + 16'd3; cyc = 4; end
            8'h8E: begin mwr(ab, m_x); nxt = m_pc + 16'd3; cyc = 4; end
            8'h8C: begin mwr(ab, m_y); nxt = m_pc + 16'd3; cyc = 4; end
            8'hE6: begin v = mrd(zp) + 8'd1; mwr(zp, v); setnz(v); nxt = m_pc + 16'd2; cyc = 5; end
            8'hC6: begin v = mrd(zp) - 8'd1; mwr(zp, v); setnz(v); nxt = m_pc + 16'd2; cyc = 5; end
            8'hEE: begin v = mrd(ab) + 8'd1; mwr(ab, v); setnz(v); nxt = m_pc + 16'd3; cyc = 6; end
            8'hCE: begin v = mrd(ab) - 8'd1; mwr(ab, v); setnz(v); nxt = m_pc + 16'd3; cyc = 6; end
            8'hE8: begin m_x = m_x + 8'd1; setnz(m_x); end
            8'hC8: begin m_y = m_y + 8'd1; setnz(m_y); end
            8'hCA: begin m_x = m_x - 8'd1; setnz(m_x); end
            8'h88: begin m_y = m_y - 8'd1; setnz(m_y); end
            8'hAA: begin m_x = m_a; setnz(m_x); end
            8'h8A: begin m_a = m_x; setnz(m_a); end
            8'hA8: begin m_y = m_a; setnz(m_y); end
            8'h98: begin m_a = m_y; setnz(m_a); end
            8'h18: m_c = 1'b0;
            8'h38: m_c = 1'b1;
            8'hC9: begin
                v   = m_a - b1;
                m_c = (m_a >= b1);
                m_z = (m_a == b1);
                m_n = v[7];
                nxt = m_pc + 16'd2;
            end
            8'hF0, 8'hD0: begin
                nxt = m_pc + 16'd2;
                if ((op == 8'hF0) ? m_z : !m_z) begin
                    nxt = nxt + {{8{b1[7]}}, b1};
                    cyc = 3;
                end
            end
            8'h4C: begin nxt = ab; cyc = 3; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // ---------------- program construction ----------------
    task automatic emit1(input logic [7:0] a);
        prog.push_back(a);
    endtask
    task automatic emit2(input logic [7:0] a, input logic [7:0] b);
        prog.push_back(a); prog.push_back(b);
    endtask
    task automatic emit3(input logic [7:0] a, input logic [15:0] w);
        prog.push_back(a); prog.push_back(w[7:0]); prog.push_back(w[15:8]);
    endtask

    // Close the program with a jump-to-self that marks the end of execution
    task automatic finalize_prog();
        halt_pc = 16'hF000 + 16'(prog.size());
        emit3(8'h4C, halt_pc);
    endtask

    function automatic logic [7:0] pick3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        case ($urandom_range(0, 2))
            0:       return a;
            1:       return b;
            default: return c;
        endcase
    endfunction

    function automatic logic [15:0] rnd_abs();
        case ($urandom_range(0, 5))
            4:       return 16'h1234;
            5:       return 16'hF800;
            default: return 16'h0200 + 16'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic gen_random(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 10))
                0: emit2(pick3(8'hA9, 8'hA2, 8'hA0), 8'($urandom));
                1: emit2(pick3(8'hA5, 8'hA6, 8'hA4), 8'($urandom_range(0, 15)));
                2: emit3(pick3(8'hAD, 8'hAE, 8'hAC), rnd_abs());
                3: emit2(pick3(8'h85, 8'h86, 8'h84), 8'($urandom_range(0, 15)));
                4: emit3(pick3(8'h8D, 8'h8E, 8'h8C), rnd_abs());
                5: emit2(($urandom_range(0, 1) == 0) ? 8'hE6 : 8'hC6, 8'($urandom_range(0, 15)));
                6: emit3(($urandom_range(0, 1) == 0) ? 8'hEE : 8'hCE, rnd_abs());
                7: emit1(impl_ops[$urandom_range(0, 11)]);
                8: emit2(8'hC9, 8'($urandom));
                9: begin
                    // forward branch of 0 or 1 byte over a single-byte filler
                    emit2(($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hD0, 8'($urandom_range(0, 1)));
                    emit1(8'hE8);
                end
                default: emit2(8'hA9, 8'($urandom_range(0, 2)));
            endcase
        end
        finalize_prog();
    endtask

    // ---------------- run control ----------------
    // Hold reset, load ROM image (and optionally clear RAM), check reset state
    task automatic apply_reset(input bit clear_ram);
        reset = 1'b1;
        if (clear_ram) begin
            for (int i = 0; i < 4096; i++) begin
                m_rom[i] = (i < prog.size()) ? prog[i] : 8'hEA;
                m_ram[i] = 8'h00;
            end
            m_rom[4092] = 8'h00;
            m_rom[4093] = 8'hF0;
            for (int i = 0; i < 4096; i++) begin
                dut.mem.ROM[i] <= m_rom[i];
                dut.mem.RAM[i] <= 8'h00;
            end
        end
        tick(2);
        model_reset();
        check_eq("reset_a", 32'(dut.r_a), 32'(m_a));
        check_eq("reset_x", 32'(dut.r_x), 32'(m_x));
        check_eq("reset_y", 32'(dut.r_y), 32'(m_y));
        check_eq("reset_p", 32'(p_of(dut.r_n, dut.r_z, dut.r_c)), 32'(p_of(m_n, m_z, m_c)));
    endtask

    // Release reset; the third rising ph2 after release lands on the first opcode fetch
    task automatic release_reset();
        reset = 1'b0;
        tick(3);
        check_eq("first_fetch", 32'({dut.w_sync, dut.w_addr}), 32'({1'b1, m_pc}));
    endtask

    task automatic run_to_halt(input string name);
        int steps = 0;
        int cycles = 0;
        int c;
        int ram_bad = 0;
        while (m_pc != halt_pc && steps < 400) begin
            model_step(c);
            cycles += c;
            steps++;
        end
        if (m_pc != halt_pc) check_eq({name, "_model_halt"}, 32'(m_pc), 32'(halt_pc));
        tick(cycles);
        check_eq({name, "_fetch_pc"}, 32'({dut.w_sync, dut.w_addr}), 32'({1'b1, halt_pc}));
        check_eq({name, "_a"}, 32'(dut.r_a), 32'(m_a));
        check_eq({name, "_x"}, 32'(dut.r_x), 32'(m_x));
        check_eq({name, "_y"}, 32'(dut.r_y), 32'(m_y));
        check_eq({name, "_p"}, 32'(p_of(dut.r_n, dut.r_z, dut.r_c)), 32'(p_of(m_n, m_z, m_c)));
        for (int i = 0; i < 4096; i++) begin
            if (dut.mem.RAM[i] !== m_ram[i]) ram_bad++;
        end
        check_eq({name, "_ram_mismatches"}, 32'(ram_bad), 32'd0);
        $display("prog %s: instr=%0d cycles=%0d A=%02h X=%02h Y=%02h P=%02h",
                 name, steps, cycles, dut.r_a, dut.r_x, dut.r_y, p_of(dut.r_n, dut.r_z, dut.r_c));
    endtask

    task automatic run_prog(input string name);
        finalize_prog();
        apply_reset(1'b1);
        release_reset();
        run_to_halt(name);
    endtask

    initial begin
        impl_ops[0] = 8'hE8; impl_ops[1]  = 8'hC8; impl_ops[2]  = 8'hCA; impl_ops[3]  = 8'h88;
        impl_ops[4] = 8'hAA; impl_ops[5]  = 8'h8A; impl_ops[6]  = 8'hA8; impl_ops[7]  = 8'h98;
        impl_ops[8] = 8'h18; impl_ops[9]  = 8'h38; impl_ops[10] = 8'hEA; impl_ops[11] = 8'h02;
        reset = 1'b1;

        // DEC through zero page: 0x00 - 1 wraps to 0xFF with N set
        prog.delete();
        emit2(8'hA9, 8'h00); emit2(8'h85, 8'h71); emit2(8'hC6, 8'h71);
        run_prog("dec_zp");
        check_eq("dec_zp_ram71", 32'(dut.mem.RAM[12'h071]), 32'h0000_00FF);
        check_eq("dec_zp_flags", 32'(p_of(dut.r_n, dut.r_z, dut.r_c)), 32'h0000_00A0);

        // INX wrap to zero
        prog.delete();
        emit2(8'hA2, 8'hFF); emit1(8'hE8);
        run_prog("inx_wrap");
        check_eq("inx_wrap_zflag", 32'(dut.r_z), 32'd1);

        // DEY wrap to 0xFF
        prog.delete();
        emit2(8'hA0, 8'h00); emit1(8'h88);
        run_prog("dey_wrap");
        check_eq("dey_wrap_y", 32'(dut.r_y), 32'h0000_00FF);

        // Absolute read-modify-write
        prog.delete();
        emit2(8'hA9, 8'h7F); emit3(8'h8D, 16'h0200); emit3(8'hEE, 16'h0200);
        run_prog("inc_abs");
        check_eq("inc_abs_ram200", 32'(dut.mem.RAM[12'h200]), 32'h0000_0080);

        // Backward branch loop: LDX #5; loop: DEX; BNE loop; STX $10
        prog.delete();
        emit2(8'hA2, 8'h05); emit1(8'hCA); emit2(8'hD0, 8'hFD); emit2(8'h86, 8'h10);
        run_prog("bne_loop");
        check_eq("bne_loop_ram10", 32'(dut.mem.RAM[12'h010]), 32'h0000_0000);

        // Compare, carry and BEQ mix including ROM/unmapped writes being ignored
        prog.delete();
        emit2(8'hA9, 8'h10); emit2(8'hC9, 8'h10); emit2(8'hF0, 8'h01); emit1(8'hE8);
        emit2(8'hC9, 8'h20); emit1(8'h38); emit1(8'hAA); emit3(8'h8E, 16'hF800);
        emit3(8'h8D, 16'h1234); emit3(8'hAD, 16'hF000); emit1(8'hA8); emit1(8'h18);
        emit2(8'h84, 8'h05);
        run_prog("cmp_mix");

        // Reset during the MODIFY cycle of INC $30: no write, vector refetch
        prog.delete();
        emit2(8'hA9, 8'h05); emit2(8'h85, 8'h30); emit2(8'hE6, 8'h30);
        finalize_prog();
        apply_reset(1'b1);
        release_reset();
        begin
            int c1, c2;
            model_step(c1);
            model_step(c2);
            tick(c1 + c2 + 3);
        end
        check_eq("midrst_in_modify_addr", 32'(dut.w_addr), 32'h0000_0030);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_ram30_untouched", 32'(dut.mem.RAM[12'h030]), 32'(m_ram[12'h030]));
        apply_reset(1'b0);
        release_reset();
        run_to_halt("midrst_rerun");
        check_eq("midrst_rerun_ram30", 32'(dut.mem.RAM[12'h030]), 32'h0000_0006);

        // Random programs against the model
        for (int r = 0; r < 8; r++) begin
            gen_random(30);
            apply_reset(1'b1);
            release_reset();
            run_to_halt($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/top_system.md
# top_system

Minimal 6502-compatible microcomputer: a reduced-opcode 8-bit CPU core plus an on-chip memory block holding a 4 KB ROM and a 4 KB RAM. It is the top level of the regression environment. Programs are preloaded into ROM by the bench, and results are checked by reading RAM through the hierarchy. There are no data outputs.

## Interface
- Parameters: none.
- ph1  input  1  phase 1 of the system clock. Non-overlapping with ph2; 20 ns period.
- ph2  input  1  phase 2 of the system clock. All architectural state updates on rising ph2.
- reset  input  1  reset.
- One clock; reset is synchronous and active-high.
- ph1/ph2 are the two phases of that single clock. reset is sampled on rising ph2.
- Required hierarchy: a memory instance named `mem`, containing arrays `ROM[0:4095]` and `RAM[0:4095]` of 8-bit entries. Benches preload and inspect these arrays directly.

## Operation
- Address map:
  - 0x0000–0x0FFF → RAM[addr[11:0]], read/write.
  - 0xF000–0xFFFF → ROM[addr[11:0]], read-only.
  - Other addresses read 0x00; writes there are ignored.
- Memory reads are combinational from the arrays. Writes occur on rising ph2 when the write enable is set.
- CPU registers:
  - A, X, Y: 8-bit.
  - PC: 16-bit.
  - P: flags N, Z, C, plus a fixed 1 in bit 5.
  - Internal: IR, 16-bit address latch, 8-bit data latch.
- Reset:
  - While reset=1: A=X=Y=0, P=0x20, state=RESET.
  - First cycle after release: read 0xFFFC (low byte of the vector).
  - Second cycle: read 0xFFFD (high byte), then load PC from the vector.
  - Example: ROM[4092]=0x00 and ROM[4093]=0xF0 give a first fetch at 0xF000.
- Required opcodes (standard 6502 encodings):
  - LDA/LDX/LDY: imm, zp, abs.
  - STA/STX/STY: zp, abs.
  - INC/DEC: zp, abs.
  - Register ops: INX, INY, DEX, DEY, TAX, TXA, TAY, TYA.
  - Compare/carry: CMP imm, CLC, SEC.
  - Branches: BEQ, BNE (signed 8-bit offset relative to the next instruction).
  - Other: JMP abs, NOP.
- Unsupported opcodes execute as 1-byte NOPs.
- Flags:
  - Loads, INC/DEC, INX/INY/DEX/DEY and transfers set Z=(result==0) and N=result[7].
  - Stores, JMP and branches leave flags unchanged.
  - CMP sets C=(A≥imm), Z=(A==imm), N=(A−imm)[7].
- Arithmetic is 8-bit with wrap-around: 0xFF+1=0x00 (Z=1); 0x00−1=0xFF (N=1).
- INC/DEC memory is read-modify-write: read cycle, then a write of the new value. The result is flag-updated from the new value.
- FSM states: RESET, VECLO, VECHI, FETCH, OPLO, OPHI, READ, MODIFY, WRITE, BRANCH.
  - FETCH: latch opcode from mem[PC]; PC+=1.
  - Operand states: read operand bytes; PC+=1 per byte.
  - Execute path: zp/abs ops go to READ or WRITE; RMW ops go READ → MODIFY → WRITE.
  - All paths return to FETCH.
- PC increment wraps 0xFFFF→0x0000.

## Timing
- One CPU cycle = one ph1/ph2 period.
- Reset to first opcode fetch: 3 cycles after reset falls (VECLO, VECHI, FETCH).
- Cycles per instruction:
  - Implied/transfer: 2.
  - Immediate: 2.
  - zp load/store: 3.
  - abs load/store: 4.
  - JMP: 3.
  - zp INC/DEC: 5.
  - abs INC/DEC: 6.
  - Branch: 2 not taken, 3 taken.
- A store or RMW write is visible in RAM at the rising ph2 ending its WRITE cycle.
- Reset asserted mid-instruction: the instruction is aborted at the next rising ph2 with no further memory writes, and the vector sequence restarts after release.

## Test plan
- Reset vector: ROM[4093]=0xF0, ROM[4092]=0x00, program at 0xF000 → first opcode fetch at 0xF000 in cycle 3 after release.
- INC/DEC memory: LDA #0x00; STA $71; DEC $71 → RAM[0x71]=0xFF, N=1, Z=0, within 100 cycles of reset release.
- Register wrap: LDX #0xFF; INX → X=0x00, Z=1. LDY #0x00; DEY → Y=0xFF, N=1.
- Absolute RMW: LDA #0x7F; STA $0200; INC $0200 → RAM[0x200]=0x80, N=1.
- Branch loop: LDX #0x05; loop DEX; BNE loop; STX $10 → RAM[0x10]=0x00 after 5 iterations; taken branches cost 3 cycles.
- Mid-instruction reset: assert reset during the MODIFY cycle of an INC → target byte unchanged, refetch from the vector.
